fifo_apb_master: RTL and testbench
==================================

FIFO_APB_MASTER -- requirements
Module: fifo_apb_master

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DSIZE  32  FIFO word and APB data width
- AWIDTH  16  APB address width, ≤ DSIZE-1
- TIMEOUT  16  maximum ACCESS cycles with pready low before abort, ≥ 2
REQ-002 Ports, one per line: name  direction  width  meaning.
- write_clk  in  1  block clock; also clocks the APB interface
- read_reset_n  in  1  asynchronous active-low reset
- read_empty  in  1  FIFO read port empty flag
- read_data  in  DSIZE  FIFO head word; valid whenever read_empty=0
- read_enable  out  1  pop request; a word is consumed at a rising edge where read_enable=1 and read_empty=0
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  AWIDTH  APB address
- pwdata  out  DSIZE  APB write data
- prdata  in  DSIZE  APB read data
- pready, pslverr  in  1 each  APB completion and error
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accepted
- rsp_write  out  1  response belongs to a write
- rsp_err  out  1  pslverr or timeout
- rsp_data  out  DSIZE  read data, 0 for writes
- busy  out  1  state != IDLE
REQ-003 The reset shall be read_reset_n, asynchronous, active-low; the clock shall be write_clk.

Function
REQ-004 Command format: header word bit DSIZE-1 is pwrite; bits AWIDTH-1:0 are paddr; the remaining bits are ignored. A write header is followed by exactly one data word.
REQ-005 FSM states: IDLE, DATA, SETUP, ACCESS, RESP.
REQ-006 read_enable shall be combinational: 1 only in IDLE or DATA, and only while read_empty=0. It shall be 0 in every other state.
REQ-007 IDLE, on pop: latch pwrite and paddr. A write goes to DATA; a read goes to SETUP with pwdata=0.
REQ-008 DATA, on pop: latch pwdata from read_data, then go to SETUP. While read_empty=1, stay in DATA.
REQ-009 SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-010 ACCESS: psel=1, penable=1.
- pready=1 at an edge: latch prdata into rsp_data (reads only; 0 for writes), set rsp_err=pslverr, go to RESP.
REQ-011 ACCESS timeout:
- A counter counts ACCESS edges with pready=0.
- When it reaches TIMEOUT, go to RESP with rsp_err=1 and rsp_data=0.
- The counter clears on entry to SETUP.
REQ-012 RESP: psel=penable=0, rsp_valid=1, rsp_write=latched pwrite. Hold rsp_data, rsp_err and rsp_write stable until rsp_ready=1 at an edge, then go to IDLE and deassert rsp_valid.
REQ-013 paddr, pwrite and pwdata shall be registered and stable from SETUP through the last ACCESS cycle.
REQ-014 Read latency, with no wait states and rsp_ready=1:
- header pop at edge E0;
- SETUP after E0, ACCESS after E1;
- RESP with rsp_valid=1 after E2;
- IDLE after E3;
- next pop possible at E4.
REQ-015 Write latency: as REQ-014 plus one cycle per DATA wait, or one cycle minimum in DATA.
REQ-016 pslverr shall be ignored unless pready=1. prdata shall be ignored for writes.
REQ-017 At most one transaction shall be outstanding; no pop shall occur from SETUP through RESP.

Reset
REQ-018 While read_reset_n=0:
- state IDLE;
- psel, penable, pwrite, read_enable, rsp_valid, rsp_write, rsp_err = 0;
- paddr, pwdata, rsp_data = 0;
- timeout counter 0; busy=0.
REQ-019 Assertion of read_reset_n mid-transaction shall drop psel and penable immediately (asynchronously) and discard the transaction; no response shall be produced.
REQ-020 After reset deassertion, the first pop may occur at the first edge with read_empty=0.

Verification
REQ-021 Read, no wait states: header 0x0000_0040, pready=1, prdata=0xDEADBEEF, rsp_ready=1 -> one pop; paddr=0x0040, pwrite=0; psel 2 cycles, penable 1 cycle; rsp_data=0xDEADBEEF, rsp_err=0, rsp_write=1'b0.
REQ-022 Write with data word delayed: header 0x8000_0010, read_empty=1 for 3 cycles, then data 0x1234_5678 -> stays in DATA, read_enable=0 while empty; APB write to 0x0010 with pwdata=0x1234_5678; rsp_write=1, rsp_data=0.
REQ-023 Wait states and error: pready low 5 ACCESS cycles, then pready=1 with pslverr=1 -> paddr/pwdata stable throughout; rsp_err=1.
REQ-024 Timeout: TIMEOUT=16, pready held 0 -> exit after 16 ACCESS edges; psel=0, rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-025 Backpressure and reset: rsp_ready=0 for 10 cycles -> rsp_valid and response fields held, no pops. A separate run with read_reset_n pulsed low during ACCESS -> psel=penable=0 immediately, busy=0, no rsp_valid afterwards.

Source files
------------

// File: rtl/fifo_apb_master.sv
// FIFO-fed APB master: pops header (+ data for writes) words, runs one
// APB transfer, and returns a response with a wait-state timeout.
module fifo_apb_master #(
    parameter int DSIZE   = 32,
    parameter int AWIDTH  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              write_clk,
    input  logic              read_reset_n,
    input  logic              read_empty,
    input  logic [DSIZE-1:0]  read_data,
    output logic              read_enable,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AWIDTH-1:0] paddr,
    output logic [DSIZE-1:0]  pwdata,
    input  logic [DSIZE-1:0]  prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DSIZE-1:0]  rsp_data,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     tcnt, tcnt_nx;
    logic              pwrite_nx;
    logic [AWIDTH-1:0] paddr_nx;
    logic [DSIZE-1:0]  pwdata_nx;
    logic [DSIZE-1:0]  rdata_nx;
    logic              err_nx;
    logic              unused_hdr;

    // Header bits between the address and the write flag carry no meaning.
    assign unused_hdr = ^read_data;

    assign read_enable = read_reset_n && !read_empty &&
                         (state == IDLE || state == DATA);
    assign psel        = (state == SETUP) || (state == ACCESS);
    assign penable     = (state == ACCESS);
    assign rsp_valid   = (state == RESP);
    assign rsp_write   = pwrite;
    assign busy        = (state != IDLE);

    always_ff @(posedge write_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            state    <= IDLE;
            tcnt     <= '0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            tcnt     <= tcnt_nx;
            pwrite   <= pwrite_nx;
            paddr    <= paddr_nx;
            pwdata   <= pwdata_nx;
            rsp_data <= rdata_nx;
            rsp_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tcnt_nx   = tcnt;
        pwrite_nx = pwrite;
        paddr_nx  = paddr;
        pwdata_nx = pwdata;
        rdata_nx  = rsp_data;
        err_nx    = rsp_err;
        unique case (state)
            IDLE: begin
                if (read_enable) begin
                    pwrite_nx = read_data[DSIZE-1];
                    paddr_nx  = read_data[AWIDTH-1:0];
                    if (read_data[DSIZE-1]) begin
                        state_nx = DATA;
                    end else begin
                        pwdata_nx = '0;
                        tcnt_nx   = '0;
                        state_nx  = SETUP;
                    end
                end
            end
            DATA: begin
                if (read_enable) begin
                    pwdata_nx = read_data;
                    tcnt_nx   = '0;
                    state_nx  = SETUP;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rdata_nx = pwrite ? '0 : prdata;
                    err_nx   = pslverr;
                    state_nx = RESP;
                end else begin
                    tcnt_nx = tcnt + CW'(1);
                    // Abort once the slave has stalled for TIMEOUT edges.
                    if (tcnt_nx == CW'(TIMEOUT)) begin
                        rdata_nx = '0;
                        err_nx   = 1'b1;
                        state_nx = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_apb_master.sv
// Bench for fifo_apb_master: FIFO/APB slave models drive random traffic,
// a monitor compares responses against a transaction-level scoreboard.
`timescale 1ns/1ps
module tb_fifo_apb_master;

    localparam int DSIZE   = 32;
    localparam int AWIDTH  = 16;
    localparam int TIMEOUT = 16;

    logic              write_clk = 1'b0;
    logic              read_reset_n;
    logic              read_empty;
    logic [DSIZE-1:0]  read_data;
    logic              read_enable;
    logic              psel, penable, pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [DSIZE-1:0]  pwdata;
    logic [DSIZE-1:0]  prdata;
    logic              pready, pslverr;
    logic              rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [DSIZE-1:0]  rsp_data;
    logic              busy;

    always #5 write_clk = ~write_clk;

    fifo_apb_master #(
        .DSIZE(DSIZE),
        .AWIDTH(AWIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .write_clk(write_clk),
        .read_reset_n(read_reset_n),
        .read_empty(read_empty),
        .read_data(read_data),
        .read_enable(read_enable),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_err(rsp_err),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] word;
        int          dly;
    } word_t;

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] prd;
        int          waits;
        logic        err;
    } txn_t;

    typedef struct {
        logic        w;
        logic        err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    word_t fifo_q[$];
    txn_t  apb_q[$];
    exp_t  exp_q[$];
    int    pop_cyc_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit lat_on = 0;
    bit rdy_rand = 0;
    bit data_next = 0;
    bit in_txn = 0;
    int acc = 0;
    int stall = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int access_edges(input int waits);
        return (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
    endfunction

    task automatic send(input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [31:0] prd,
                        input int waits, input logic err,
                        input int dh, input int dd);
        txn_t        t;
        exp_t        e;
        word_t       wd;
        logic [31:0] hdr;
        hdr        = $urandom;
        hdr[31]    = w;
        hdr[15:0]  = a;
        wd.word    = hdr;
        wd.dly     = dh;
        fifo_q.push_back(wd);
        if (w) begin
            wd.word = d;
            wd.dly  = dd;
            fifo_q.push_back(wd);
        end
        t.w = w; t.addr = a; t.data = d;
        t.prd = prd; t.waits = waits; t.err = err;
        apb_q.push_back(t);
        e.w    = w;
        e.err  = (waits >= TIMEOUT) ? 1'b1 : err;
        e.data = (w || waits >= TIMEOUT) ? 32'h0 : prd;
        e.lat  = lat_on ? 2 + access_edges(waits) + (w ? 1 + dd : 0) : -1;
        exp_q.push_back(e);
    endtask

    task automatic step();
        txn_t  t;
        word_t hw;
        @(negedge write_clk);
        cyc++;
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
        if (psel && !penable) begin
            chk("setup_once", {63'h0, in_txn}, 64'h0);
            if (apb_q.size() == 0) begin
                chk("apb_spurious", psel, 0);
            end else begin
                t = apb_q[0];
                chk("setup_paddr", paddr, t.addr);
                chk("setup_pwrite", pwrite, t.w);
                chk("setup_pwdata", pwdata, t.w ? t.data : 32'h0);
                in_txn = 1;
                acc    = 0;
            end
        end else if (psel && penable) begin
            chk("access_after_setup", {63'h0, in_txn}, 64'h1);
            if (in_txn) begin
                t = apb_q[0];
                chk("hold_paddr", paddr, t.addr);
                chk("hold_pwrite", pwrite, t.w);
                chk("hold_pwdata", pwdata, t.w ? t.data : 32'h0);
                if (acc >= t.waits) begin
                    pready  = 1'b1;
                    pslverr = t.err;
                    prdata  = t.prd;
                end
                acc++;
            end
        end else if (in_txn) begin
            t = apb_q.pop_front();
            chk("access_cycles", acc, access_edges(t.waits));
            in_txn = 0;
        end
        if (fifo_q.size() == 0) begin
            read_empty = 1'b1;
            read_data  = $urandom;
        end else if (fifo_q[0].dly > 0) begin
            hw = fifo_q[0];
            hw.dly--;
            fifo_q[0]  = hw;
            read_empty = 1'b1;
            read_data  = $urandom;
        end else begin
            read_empty = 1'b0;
            read_data  = fifo_q[0].word;
        end
        if (!rdy_rand) begin
            rsp_ready = 1'b1;
        end else if (stall > 0) begin
            rsp_ready = 1'b0;
            stall--;
        end else if ($urandom_range(0, 19) == 0) begin
            rsp_ready = 1'b0;
            stall = 9;
        end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        #1;
        if (read_enable) begin
            chk("pop_legal", {read_empty, psel, rsp_valid}, 3'b000);
        end
        if (read_enable && !read_empty) begin
            hw = fifo_q.pop_front();
            if (!data_next) begin
                pop_cyc_q.push_back(cyc);
                data_next = hw.word[31];
            end else begin
                data_next = 0;
            end
        end
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 ||
                apb_q.size() != 0 || busy) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_pending", exp_q.size() + fifo_q.size(), 0);
    endtask

    bit          hv = 0;
    logic        h_w, h_e;
    logic [31:0] h_d;

    always begin
        exp_t e;
        int   pc;
        @(negedge write_clk);
        #2;
        if (!read_reset_n) begin
            hv = 0;
        end else begin
            if (hv) begin
                chk("bp_valid", rsp_valid, 1);
                chk("bp_write", rsp_write, h_w);
                chk("bp_err", rsp_err, h_e);
                chk("bp_data", rsp_data, h_d);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", rsp_valid, 0);
                end else begin
                    e  = exp_q.pop_front();
                    pc = (pop_cyc_q.size() != 0) ? pop_cyc_q.pop_front() : -1;
                    chk("rsp_write", rsp_write, e.w);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_data", rsp_data, e.data);
                    if (e.lat >= 0) chk("latency", cyc - pc, e.lat);
                end
            end
            hv  = rsp_valid && !rsp_ready;
            h_w = rsp_write;
            h_e = rsp_err;
            h_d = rsp_data;
        end
    end

    initial begin
        int n;
        read_reset_n = 1'b0;
        read_empty   = 1'b0;
        read_data    = 32'h8000_0010;
        prdata       = '0;
        pready       = 1'b0;
        pslverr      = 1'b0;
        rsp_ready    = 1'b1;
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_read_enable", read_enable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_write", rsp_write, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        read_empty = 1'b1;
        @(negedge write_clk);
        read_reset_n = 1'b1;

        lat_on   = 1;
        rdy_rand = 0;
        send(0, 16'h0040, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
        send(1, 16'h0010, 32'h1234_5678, $urandom, 0, 0, 0, 3);
        send(0, 16'h00A4, 32'h0, 32'hCAFE_F00D, 5, 1, 0, 0);
        send(1, 16'h0200, 32'hA5A5_A5A5, 32'h0, 5, 1, 1, 1);
        send(0, 16'h0300, 32'h0, 32'h1111_1111, TIMEOUT + 4, 0, 0, 0);
        send(1, 16'hFFFC, 32'h0BAD_F00D, 32'h0, TIMEOUT, 0, 0, 2);
        send(0, 16'h0304, 32'h0, 32'h2222_2222, TIMEOUT - 1, 0, 2, 0);
        run_idle(600);

        lat_on   = 0;
        rdy_rand = 1;
        repeat (80) begin
            int w8;
            w8 = ($urandom_range(0, 9) == 0) ?
                 $urandom_range(TIMEOUT - 1, TIMEOUT + 2) :
                 $urandom_range(0, 4);
            send(1'($urandom), 16'($urandom), $urandom, $urandom, w8,
                 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        run_idle(8000);

        rdy_rand = 0;
        send(0, 16'h0123, 32'h0, 32'h55AA_55AA, TIMEOUT + 10, 0, 0, 0);
        n = 0;
        while (!(psel && penable) && n < 50) begin
            step();
            n++;
        end
        chk("reached_access", penable, 1);
        #2;
        read_reset_n = 1'b0;
        #1;
        chk("arst_psel", psel, 0);
        chk("arst_penable", penable, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        fifo_q.delete();
        apb_q.delete();
        exp_q.delete();
        pop_cyc_q.delete();
        in_txn    = 0;
        data_next = 0;
        step();
        step();
        read_reset_n = 1'b1;
        repeat (20) begin
            step();
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_psel", psel, 0);
        end

        lat_on = 1;
        send(0, 16'h0044, 32'h0, 32'h600D_CAFE, 1, 0, 0, 0);
        send(1, 16'h0048, 32'hFEED_BEEF, 32'h0, 0, 1, 0, 0);
        run_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
